layer1_buf_ctrl: RTL

//  Access controller for the 912x128 dual-port layer1 SRAM wrapper.

---
 rtl/layer1_buf_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/layer1_buf_ctrl.sv
// Access controller for the layer1 dual-port SRAM: sequential port A writer, in-order port B reader.
// Optional stall counters are compiled in when LAYER1_BUF_PERF_EN is defined.
module layer1_buf_ctrl #(
   parameter int DEPTH = 912,
   parameter int AW    = 10,
   parameter int DW    = 128
) (
   input  logic          CK,
   input  logic          RSTN,
   input  logic          clear,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] wr_count,
   output logic          full,
   input  logic          rq_valid,
   output logic          rq_ready,
   input  logic [AW-1:0] rq_addr,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          sram_OEA,
   output logic          sram_OEB,
   output logic          sram_WEAN,
   output logic          sram_WEBN,
   output logic [AW-1:0] sram_A,
   output logic [AW-1:0] sram_B,
   output logic [DW-1:0] sram_DIA,
   output logic [DW-1:0] sram_DIB,
   input  logic [DW-1:0] sram_DOB
`ifdef LAYER1_BUF_PERF_EN
   ,
   output logic [31:0]   perf_wr_stall,
   output logic [31:0]   perf_rd_stall
`endif
);

   localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] wr_count_reg, wr_count_next;
   logic          wr_hs;
   logic          last_word;

   logic          inflight_valid_reg;
   logic          inflight_oor_reg;
   logic [1:0]    occ_reg;
   logic          rd_ptr_reg;
   logic          wr_ptr_reg;
   logic [DW-1:0] fifo_mem [0:1];

   logic          rq_in_range;
   logic          rq_oor;
   logic [2:0]    outstanding;
   logic          rq_hs;
   logic          rd_hs;
   logic          push;
   logic          pop;
   logic [DW-1:0] inflight_data;
   logic [DW-1:0] head_data;

   assign wr_count  = wr_count_reg;
   assign full      = (wr_count_reg == DEPTH_W);
   assign last_word = (wr_count_reg == DEPTH_W - AW'(1));

   assign sram_OEA  = 1'b0;
   assign sram_WEBN = 1'b1;
   assign sram_DIB  = '0;

   // Write-side FSM; the FULL state is what closes the write stream.
   always_comb begin
      state_next    = state_reg;
      wr_ready      = !clear && (state_reg != ST_FULL);
      wr_hs         = wr_valid && wr_ready;
      wr_count_next = wr_count_reg;
      sram_WEAN     = 1'b1;
      sram_A        = '0;
      sram_DIA      = '0;

      if (wr_hs) begin
         sram_WEAN     = 1'b0;
         sram_A        = wr_count_reg;
         sram_DIA      = wr_data;
         wr_count_next = wr_count_reg + AW'(1);
      end

      case (state_reg)
         ST_IDLE: if (wr_hs) state_next = last_word ? ST_FULL : ST_FILL;
         ST_FILL: if (wr_hs && last_word) state_next = ST_FULL;
         ST_FULL: state_next = ST_FULL;
         default: state_next = ST_IDLE;
      endcase

      if (clear) begin
         state_next    = ST_IDLE;
         wr_count_next = '0;
      end
   end

   // Only addresses already written are readable, so port B never meets port A's current address.
   always_comb begin
      rq_in_range   = (rq_addr < wr_count_reg);
      rq_oor        = (rq_addr >= DEPTH_W);
      outstanding   = {1'b0, occ_reg} + {2'b00, inflight_valid_reg};
      rq_ready      = !clear && (rq_in_range || rq_oor) && (outstanding < 3'd2);
      rq_hs         = rq_valid && rq_ready;
      sram_OEB      = rq_hs && !rq_oor;
      sram_B        = sram_OEB ? rq_addr : '0;

      inflight_data = inflight_oor_reg ? '0 : sram_DOB;
      head_data     = (occ_reg != 2'd0) ? fifo_mem[rd_ptr_reg] : inflight_data;
      rd_valid      = !clear && ((occ_reg != 2'd0) || inflight_valid_reg);
      rd_data       = rd_valid ? head_data : '0;
      rd_hs         = rd_valid && rd_ready;
      pop           = rd_hs && (occ_reg != 2'd0);
      // A returning word bypasses the FIFO only when the FIFO is empty and the consumer takes it now.
      push          = inflight_valid_reg && !((occ_reg == 2'd0) && rd_hs);
   end

   always_ff @(posedge CK) begin
      if (!RSTN) begin
         state_reg          <= ST_IDLE;
         wr_count_reg       <= '0;
         inflight_valid_reg <= 1'b0;
         inflight_oor_reg   <= 1'b0;
         occ_reg            <= 2'd0;
         rd_ptr_reg         <= 1'b0;
         wr_ptr_reg         <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wr_count_reg <= wr_count_next;
         if (clear) begin
            inflight_valid_reg <= 1'b0;
            inflight_oor_reg   <= 1'b0;
            occ_reg            <= 2'd0;
            rd_ptr_reg         <= 1'b0;
            wr_ptr_reg         <= 1'b0;
         end else begin
            inflight_valid_reg <= rq_hs;
            inflight_oor_reg   <= rq_hs && rq_oor;
            if (push) wr_ptr_reg <= !wr_ptr_reg;
            if (pop)  rd_ptr_reg <= !rd_ptr_reg;
            case ({push, pop})
               2'b10:   occ_reg <= occ_reg + 2'd1;
               2'b01:   occ_reg <= occ_reg - 2'd1;
               default: occ_reg <= occ_reg;
            endcase
         end
      end
   end

   always_ff @(posedge CK) begin
      if (push) fifo_mem[wr_ptr_reg] <= inflight_data;
   end

`ifdef LAYER1_BUF_PERF_EN
   always_ff @(posedge CK) begin
      if (!RSTN || clear) begin
         perf_wr_stall <= '0;
         perf_rd_stall <= '0;
      end else begin
         if (wr_valid && !wr_ready && (perf_wr_stall != '1)) perf_wr_stall <= perf_wr_stall + 32'd1;
         if (rq_valid && !rq_ready && (perf_rd_stall != '1)) perf_rd_stall <= perf_rd_stall + 32'd1;
      end
   end
`endif

endmodule
